// File: rtl/pc_bus_capture.sv
// pc_bus_capture
//   Reader end of the tri-state PC register bus. On each Tick it selects the
//   PC register (cs_n low), lets the bus settle for one cycle, samples it on
//   the next, and queues the value in a small FIFO. A trace consumer drains
//   the FIFO through a valid/ready handshake.
//
// Ports
//   Clock        in   single clock, rising-edge
//   Reset        in   synchronous, active-high; priority over all inputs
//   ClockEnable  in   global stall for the capture FSM (pops ignore it)
//   Tick         in   capture request, one pulse per retired instruction
//   bus_in       in   shared PC bus (register Q output)
//   cs_n         out  registered chip-select of the PC register, active low
//   trace_data   out  FIFO head value
//   trace_valid  out  FIFO non-empty
//   trace_ready  in   consumer accepts the head
//   level        out  FIFO occupancy
//   drop_count   out  lost captures, saturating at 0xFFFF

module pc_bus_capture #(
  parameter int NrOfBits = 32,
  parameter int Depth    = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     ClockEnable,
  input  logic                     Tick,
  input  logic [NrOfBits-1:0]      bus_in,
  output logic                     cs_n,
  output logic [NrOfBits-1:0]      trace_data,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [$clog2(Depth):0]   level,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(Depth);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [NrOfBits-1:0] mem [Depth];

  logic empty;
  logic full;
  logic push_req;
  logic push;
  logic pop;
  logic overflow;
  logic busy_tick;
  logic drop_inc;

  // Handshake: the head is transferred on a rising edge where
  // trace_valid && trace_ready. trace_valid never depends on trace_ready, and
  // trace_data holds its value while trace_valid is high and trace_ready low.
  assign empty       = (wr_ptr == rd_ptr);
  assign level       = wr_ptr - rd_ptr;
  assign full        = (level == LEVEL_FULL);
  assign trace_valid = !empty;
  assign trace_data  = mem[rd_ptr[AW-1:0]];
  assign pop         = trace_valid && trace_ready;

  // A full FIFO still accepts the sample when the head leaves in the same
  // cycle: the write lands in the slot being vacated.
  assign push_req  = (state == SAMPLE) && ClockEnable;
  assign push      = push_req && (!full || pop);
  assign overflow  = push_req && full && !pop;
  assign busy_tick = Tick && ClockEnable && (state != IDLE);
  // Busy-tick and overflow in one cycle still count as a single loss.
  assign drop_inc  = (overflow || busy_tick) && (drop_count != 16'hFFFF);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Tick && ClockEnable) state_next = SELECT;
      SELECT:  if (ClockEnable)         state_next = SAMPLE;
      SAMPLE:  if (ClockEnable)         state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cs_n       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_next;
      // cs_n is a flop driven from the next state, so it is low exactly
      // while the FSM sits in SELECT or SAMPLE and cannot glitch.
      cs_n  <= (state_next == IDLE);
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= bus_in;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop_inc) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_bus_capture.sv
// tb_pc_bus_capture
//   Directed bench for pc_bus_capture (NrOfBits=32, Depth=4). Stimulus pushes
//   the PC values that must come out of the FIFO into exp_q; a monitor on the
//   falling edge pops and compares whenever a transfer is about to happen.
//   Inputs change 1 ns after the rising edge; outputs are sampled at 1 ns
//   after the rising edge (direct checks) or on the falling edge (monitor).

module tb_pc_bus_capture;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          ce;
  logic          tick;
  logic [W-1:0]  bus_in;
  logic          cs_n;
  logic [W-1:0]  trace_data;
  logic          trace_valid;
  logic          trace_ready;
  logic [2:0]    level;
  logic [15:0]   drop_count;

  logic [W-1:0]  exp_q[$];
  int            checks;
  int            errors;

  pc_bus_capture #(.NrOfBits(W), .Depth(4)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .ClockEnable (ce),
    .Tick        (tick),
    .bus_in      (bus_in),
    .cs_n        (cs_n),
    .trace_data  (trace_data),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .level       (level),
    .drop_count  (drop_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse Tick for one edge with the given PC on the bus, then hold the bus
  // through the SAMPLE edge (3 cycles total, the lossless spacing).
  task automatic capture(input logic [W-1:0] pc, input bit expect_push);
    bus_in = pc;
    tick   = 1'b1;
    step();
    tick   = 1'b0;
    step();
    step();
    if (expect_push) exp_q.push_back(pc);
  endtask

  task automatic drain(input int n);
    trace_ready = 1'b1;
    repeat (n) step();
    trace_ready = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && trace_valid === 1'b1 && trace_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got 0x%08h expected no entry at %0t", trace_data, $time);
        end else begin
          chk("pop_data", trace_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    ce          = 1'b1;
    tick        = 1'b0;
    bus_in      = '0;
    trace_ready = 1'b0;

    // Reset then single capture
    do_reset();
    chk("rst_cs_n",   32'(cs_n), 32'd1);
    chk("rst_valid",  32'(trace_valid), 32'd0);
    chk("rst_drop",   32'(drop_count), 32'd0);
    chk("rst_level",  32'(level), 32'd0);
    chk("rst_data",   trace_data, 32'd0);

    bus_in = 32'h0040_0010;
    tick   = 1'b1;
    step();                                   // edge n
    tick   = 1'b0;
    chk("single_cs_n1", 32'(cs_n), 32'd0);
    step();                                   // edge n+1
    chk("single_cs_n2", 32'(cs_n), 32'd0);
    chk("single_notyet", 32'(trace_valid), 32'd0);
    step();                                   // edge n+2
    exp_q.push_back(32'h0040_0010);
    chk("single_cs_n3", 32'(cs_n), 32'd1);
    chk("single_valid", 32'(trace_valid), 32'd1);
    chk("single_data",  trace_data, 32'h0040_0010);
    chk("single_level", 32'(level), 32'd1);
    drain(1);
    chk("single_empty", 32'(level), 32'd0);

    // Fill and overflow: fifth capture is lost
    capture(32'h0, 1'b1);
    capture(32'h4, 1'b1);
    capture(32'h8, 1'b1);
    capture(32'hC, 1'b1);
    capture(32'h10, 1'b0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_drop",  32'(drop_count), 32'd1);
    chk("ovf_head",  trace_data, 32'h0);
    drain(4);
    chk("ovf_drained", 32'(level), 32'd0);

    // Full with simultaneous pop during SAMPLE
    capture(32'h100, 1'b1);
    capture(32'h104, 1'b1);
    capture(32'h108, 1'b1);
    capture(32'h10C, 1'b1);
    bus_in = 32'h20;
    tick   = 1'b1;
    step();
    tick   = 1'b0;
    step();                                   // now in SAMPLE
    trace_ready = 1'b1;
    step();                                   // push and pop together
    trace_ready = 1'b0;
    exp_q.push_back(32'h20);
    chk("fullpop_level", 32'(level), 32'd4);
    chk("fullpop_drop",  32'(drop_count), 32'd1);
    drain(4);
    chk("fullpop_drained", 32'(level), 32'd0);

    // Busy Tick: second Tick lands in SELECT
    do_reset();
    chk("busy_rst_drop", 32'(drop_count), 32'd0);
    bus_in = 32'h44;
    tick   = 1'b1;
    step();                                   // edge n: IDLE -> SELECT
    step();                                   // edge n+1: busy Tick
    tick   = 1'b0;
    step();                                   // edge n+2: push
    exp_q.push_back(32'h44);
    chk("busy_level", 32'(level), 32'd1);
    chk("busy_drop",  32'(drop_count), 32'd1);
    step();
    step();
    chk("busy_single", 32'(level), 32'd1);
    drain(1);

    // Stall in SELECT, with a pop completing during the stall
    capture(32'h50, 1'b1);
    bus_in = 32'h55;
    tick   = 1'b1;
    step();                                   // -> SELECT
    tick   = 1'b0;
    ce     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      trace_ready = (i == 2);
      step();
      chk("stall_cs_n", 32'(cs_n), 32'd0);
    end
    trace_ready = 1'b0;
    chk("stall_nocap", 32'(level), 32'd0);
    ce = 1'b1;
    step();                                   // SELECT -> SAMPLE
    chk("stall_cs_n_sample", 32'(cs_n), 32'd0);
    chk("stall_still_empty", 32'(trace_valid), 32'd0);
    step();                                   // capture
    exp_q.push_back(32'h55);
    chk("stall_cs_n_done", 32'(cs_n), 32'd1);
    chk("stall_level", 32'(level), 32'd1);
    chk("stall_data",  trace_data, 32'h55);
    drain(1);

    // Reset mid-SAMPLE
    bus_in = 32'h66;
    tick   = 1'b1;
    step();
    tick   = 1'b0;
    step();                                   // now in SAMPLE
    rst    = 1'b1;
    step();
    rst    = 1'b0;
    chk("midrst_cs_n",  32'(cs_n), 32'd1);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_valid", 32'(trace_valid), 32'd0);
    chk("midrst_drop",  32'(drop_count), 32'd0);
    step();
    step();
    chk("midrst_nopush", 32'(level), 32'd0);
    chk("midrst_cs_idle", 32'(cs_n), 32'd1);

    // Everything expected must have been drained and compared
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
